div_seq: RTL
============

# div_seq

Sequential 32-bit restoring divider for the MIPS execute stage. The ALU's DIV/DIVU path drives it as initiator with a start/ready handshake. It computes quotient and remainder over 32 iterations, signed or unsigned, and returns them in HI/LO layout: remainder in the upper word, quotient in the lower word. The ALU writes the result into hilo_out and stalls the pipeline until ready_o is asserted.

## Interface
- No parameters; widths fixed at 32-bit operands and 64-bit result.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1_i  in  32  dividend; sampled with start
- opdata2_i  in  32  divisor; sampled with start
- start_i  in  1  request; held high by the initiator until it sees ready_o
- annul_i  in  1  abort the division in flight (pipeline flush or exception)
- result_o  out  64  {remainder, quotient}; valid only while ready_o = 1, else 0
- ready_o  out  1  result valid

## Operation
- States: IDLE, BYZERO, ON, END.
- IDLE
  - start_i = 1 and annul_i = 0 → latch operands and signed_div_i.
  - Divisor == 0 (with macro, see Configuration) → BYZERO.
  - Otherwise → ON, with iteration count = 0.
  - start_i = 1 and annul_i = 1 → stay in IDLE.
- Operand preparation (signed only): a negative operand is replaced by its two's complement. The magnitude of 0x80000000 is 0x80000000 taken as unsigned.
- ON: one restoring step per cycle.
  - t = {rem, quo[31]} − {0, divisor}, 33 bits; rem starts at 0, quo starts at the dividend magnitude.
  - t ≥ 0 → rem = t[31:0], quo = {quo[30:0], 1}.
  - t < 0 → rem = {rem[30:0], quo[31]}, quo = {quo[30:0], 0}.
  - After step 32 → END.
- Sign correction, applied on entry to END:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative.
  - −2^31 / −1 gives quotient 0x80000000 and remainder 0 (wraps, no trap).
- END
  - ready_o = 1; result_o holds its value.
  - Stays in END while start_i = 1.
  - start_i = 0 → IDLE; ready_o and result_o return to 0 on that edge.
- annul_i = 1 in ON or BYZERO → IDLE on the next edge; ready_o stays 0 and partial state is discarded. annul_i is ignored in END.
- Operand input changes after the start edge have no effect.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE; ready_o = 0, result_o = 0, all internal registers cleared. Applies at any time, including mid-division.
- Edge 1 (start_i sampled in IDLE) → ON.
- Edges 2..33 perform the 32 steps; edge 33 enters END with ready_o = 1.
- ready_o therefore rises 33 edges after the first sampled start.
- BYZERO path: edge 1 → BYZERO, edge 2 → END with result_o = 0 and ready_o = 1.
- ready_o and result_o are registered outputs with no combinational path from the inputs.
- Back-to-back requests: start_i must be low for at least one edge in END. The next start is then accepted in IDLE on the following edge.

## Configuration
- DIV_ZERO_DETECT_EN
  - Defined: divisor == 0 takes the BYZERO path; result_o = 64'h0 after 2 edges.
  - Undefined: no zero detection; the divisor-zero case runs the full 32 steps. The unsigned result is {dividend, 32'hFFFFFFFF}. The signed result receives normal sign correction on the same raw values.

## Test plan
- Unsigned 100 / 7, start held → ready_o rises at edge 33; result_o = {32'd2, 32'd14}. Dropping start → ready_o = 0 on the next edge.
- Signed 0xFFFFFFF9 / 0x00000002 (−7 / 2) → result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF → result_o = {32'h0, 32'h80000000}. Unsigned 0xFFFFFFFF / 0x10 → {32'hF, 32'h0FFFFFFF}.
- Divisor 0 with the macro defined → ready_o at edge 2, result_o = 0. Unsigned 5 / 0 with the macro undefined → ready_o at edge 33, result_o = {32'd5, 32'hFFFFFFFF}.
- annul_i pulsed at edge 10 → IDLE, ready_o never asserts. A fresh 9 / 3 request then yields {0, 3} at edge 33 of that request.
- rst driven low at edge 20 of a division → ready_o = 0 and result_o = 0 immediately. After release, a 50 / 5 request yields {0, 10}.

Source files
------------

// File: rtl/div_seq.sv
// rtl/div_seq.sv - 32-bit sequential restoring divider, {remainder, quotient} result
// Optional divide-by-zero short path enabled by defining DIV_ZERO_DETECT_EN.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] div_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] diff;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] rem_fix;
    logic [31:0] quo_fix;
    logic        div_zero;

    // Signed operands are reduced to magnitudes; 0x80000000 negates to itself.
    always_comb begin
        mag1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    end

    always_comb begin
        diff    = {rem_q, quo_q[31]} - {1'b0, div_q};
        rem_d   = diff[32] ? {rem_q[30:0], quo_q[31]} : diff[31:0];
        quo_d   = {quo_q[30:0], ~diff[32]};
        rem_fix = neg_rem_q ? -rem_d : rem_d;
        quo_fix = neg_quo_q ? -quo_d : quo_d;
    end

`ifdef DIV_ZERO_DETECT_EN
    assign div_zero = (opdata2_i == 32'h0);
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 32'h0;
            quo_q     <= 32'h0;
            div_q     <= 32'h0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'h0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        rem_q     <= 32'h0;
                        quo_q     <= mag1;
                        div_q     <= mag2;
                        neg_quo_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_q <= signed_div_i && opdata1_i[31];
                        cnt_q     <= 5'd0;
                        state_q   <= div_zero ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    if (annul_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        result_q <= 64'h0;
                        ready_q  <= 1'b1;
                        state_q  <= S_END;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        rem_q   <= 32'h0;
                        quo_q   <= 32'h0;
                        cnt_q   <= 5'd0;
                        state_q <= S_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                        // Final step lands the sign-corrected result directly.
                        if (cnt_q == 5'd31) begin
                            result_q <= {rem_fix, quo_fix};
                            ready_q  <= 1'b1;
                            state_q  <= S_END;
                        end
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        result_q <= 64'h0;
                        ready_q  <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
